stopwatch_bcd: RTL
==================

// Module: stopwatch_bcd
// PURPOSE
//  Count-up elapsed-seconds stopwatch; the up-counting counterpart of the countdown timer.
//  Contains its own 1 Hz rate divider, runs under Start/Stop/Clear control and counts in
//  two-digit BCD (00-99). It drives the two hex_display digits directly.
//  Raises a one-cycle Done pulse when the count reaches a programmable BCD limit or 99.
// PARAMETERS
//  TICKS_PER_SEC  50000000  Clock cycles per counted second. Divider reload = TICKS_PER_SEC-1.
//                           Must be >= 1.
// PORTS
//  Clock    in   1  System clock (CLOCK_50 at top level).
//  Resetn   in   1  Synchronous reset, active-low.
//  Start    in   1  Level-sampled each cycle. Starts from IDLE or resumes from PAUSED.
//  Stop     in   1  Level-sampled. Pauses while in RUN.
//  Clear    in   1  Level-sampled. Returns to IDLE with count 00 from any state.
//  Limit    in   8  BCD target {tens,ones}. 8'h00 means "no limit" (run to 99).
//  Out      out  8  BCD count {tens[7:4], ones[3:0]}.
//  Running  out  1  High while in RUN.
//  Done     out  1  One-cycle pulse on entry to EXPIRED.
// BEHAVIOUR
//  Reset (Resetn=0 at posedge):
//  - state=IDLE, Out=8'h00, Running=0, Done=0.
//  - Divider counter = TICKS_PER_SEC-1.
//  States: IDLE, RUN, PAUSED, EXPIRED. Control priority per cycle: Clear > Stop > Start.
//  - IDLE:    Start -> RUN. Divider reloads to TICKS_PER_SEC-1 on this edge.
//  - RUN:     Stop -> PAUSED. Divider holds its value.
//             Otherwise divider decrements each cycle. At 0 it reloads and emits an internal
//             tick, and Out increments on that same edge.
//  - PAUSED:  Start -> RUN. Divider resumes from the held value, so there is no partial-second
//             loss.
//  - EXPIRED: Out is frozen. Start and Stop are ignored. Only Clear or reset exits.
//  - Clear in any state: -> IDLE, Out=00, divider reloaded, Done=0 that cycle.
//  Latency: first increment occurs exactly TICKS_PER_SEC cycles after the Start edge.
//  Increment arithmetic:
//  - ones 9 -> 0 with carry into tens; otherwise ones+1.
//  - Out never holds a non-BCD value.
//  Expiry: the compare uses the post-increment value.
//  - If next Out == Limit (Limit != 00), or next Out == 8'h99: state -> EXPIRED, Running=0,
//    and Done=1 for exactly the one cycle after that edge.
//  - Limit is sampled continuously. Lowering Limit below the current count does not expire;
//    the count runs on to 99.
//  - A non-BCD Limit never matches; the count expires at 99.
//  - Stop asserted on the tick edge has priority: go to PAUSED, no increment.
//  - Start and Stop both high in RUN -> PAUSED.
//  - Start and Stop both high in PAUSED -> stays PAUSED.
//  - Reset mid-run behaves identically to power-on reset. No residual tick.
// TESTING (sim with TICKS_PER_SEC=4)
//  1. Reset, Start pulse, Limit=00
//     -> Out increments every 4 cycles: 00,01,...,09,10 (BCD carry).
//     -> Running=1 throughout.
//  2. Limit=8'h05, Start
//     -> Out=05 at cycle 20 after Start.
//     -> Done=1 for one cycle, Running=0, Out stays 05 for 50 cycles despite Start pulses.
//  3. Run 2 cycles into a second, Stop for 10 cycles, then Start
//     -> next increment occurs 2 cycles after resume.
//  4. Limit=00, run 400 cycles -> Out saturates at 99, single Done pulse, EXPIRED.
//  5. Clear and Start asserted together in RUN at Out=37
//     -> Out=00, state IDLE, Running=0 next cycle.
//  6. Resetn=0 for one cycle mid-run at Out=12
//     -> Out=00, Running=0, Done=0.
//     -> A later Start gives first increment 4 cycles after the Start edge.

Source files
------------

// File: rtl/stopwatch_bcd_if.sv
// rtl/stopwatch_bcd_if.sv - control and display bundle for the BCD stopwatch
interface stopwatch_bcd_if;
    logic       start;
    logic       stop;
    logic       clear;
    logic [7:0] limit;
    logic [7:0] out;
    logic       running;
    logic       done;

    modport master (
        output start,
        output stop,
        output clear,
        output limit,
        input  out,
        input  running,
        input  done
    );

    modport slave (
        input  start,
        input  stop,
        input  clear,
        input  limit,
        output out,
        output running,
        output done
    );
endinterface

// File: rtl/stopwatch_bcd.sv
// rtl/stopwatch_bcd.sv - two-digit BCD count-up stopwatch with 1 Hz divider and limit
module stopwatch_bcd #(
    parameter int TICKS_PER_SEC = 50000000
) (
    input  logic            clk_i,
    input  logic            resetn_i,
    stopwatch_bcd_if.slave  sw
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSED,
        S_EXPIRED
    } state_t;

    localparam int              DW     = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [DW-1:0]   RELOAD = DW'(TICKS_PER_SEC - 1);

    state_t         state_q, state_d;
    logic [DW-1:0]  div_q, div_d;
    logic [7:0]     out_q, out_d;
    logic           done_q, done_d;
    logic [7:0]     out_inc;
    logic           hit;

    // BCD +1: ones wraps 9->0 and carries into tens. 99 is never incremented
    // because reaching it always expires the count.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign out_inc = bcd_inc(out_q);

    // Expiry looks at the value about to be stored. Equality only, so a limit
    // lowered below the count (or a non-BCD limit) never matches and 99 stops it.
    assign hit = ((sw.limit != 8'h00) && (out_inc == sw.limit)) || (out_inc == 8'h99);

    // State, divider, count and done-pulse registers
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q <= S_IDLE;
            div_q   <= RELOAD;
            out_q   <= 8'h00;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; Clear beats Stop beats Start
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        out_d   = out_q;
        done_d  = 1'b0;

        if (sw.clear) begin
            state_d = S_IDLE;
            out_d   = 8'h00;
            div_d   = RELOAD;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (sw.start) begin
                        state_d = S_RUN;
                        div_d   = RELOAD;
                    end
                end
                S_RUN: begin
                    if (sw.stop) begin
                        // Divider is left untouched so a resume loses no part of the second
                        state_d = S_PAUSED;
                    end else if (div_q == '0) begin
                        div_d = RELOAD;
                        out_d = out_inc;
                        if (hit) begin
                            state_d = S_EXPIRED;
                            done_d  = 1'b1;
                        end
                    end else begin
                        div_d = div_q - 1'b1;
                    end
                end
                S_PAUSED: begin
                    if (sw.start && !sw.stop) begin
                        state_d = S_RUN;
                    end
                end
                S_EXPIRED: begin
                    state_d = S_EXPIRED;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign sw.out     = out_q;
    assign sw.running = (state_q == S_RUN);
    assign sw.done    = done_q;

endmodule
